execute_stage: RTL
==================

# execute_stage

Registered Y86-64 execute stage sitting directly downstream of decode and upstream of the memory stage. It wraps the 64-bit ALU (add/sub/and/xor) with operand selection per `icode`, holds the condition-code register (ZF/SF/OF), evaluates jump/cmov conditions, and presents `valE`/`cnd` through a one-entry valid/ready output register.

## Interface
- `W`, 64: datapath width.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: synchronous active-low reset.
- `in_valid`  in  1: decode presents an instruction.
- `in_ready`  out  1: stage can accept this cycle.
- `icode`, `ifun`  in  4 each: instruction code/function.
- `valA`, `valB`, `valC`  in  W each: operands from decode.
- `dstE`  in  4: destination register; 4'hF = RNONE.
- `cc_inhibit`  in  1: suppress CC update (exception downstream).
- `out_valid`  out  1: result register holds valid data.
- `out_ready`  in  1: memory stage consumes.
- `valE`  out  W: execute result.
- `cnd`  out  1: condition outcome.
- `dstE_out`  out  4: `dstE`, forced to RNONE for a cmov with `cnd`=0.
- `icode_out`  out  4: forwarded `icode`.
- `cc`  out  3: {ZF,SF,OF}, registered.
- `err`  out  1: invalid `icode`/`ifun` seen on the accepted instruction.

## Operation
- Accept when `in_valid & in_ready`; `in_ready = ~out_valid | out_ready` (combinational).
- valE by icode: 0/1 halt/nop -> 0; 2 rrmovq/cmovXX -> valA; 3 irmovq -> valC; 4/5 rmmovq/mrmovq -> valB+valC; 6 OPq -> valB op valA; 7 jXX -> 0; 8/A call/pushq -> valB-8; 9/B ret/popq -> valB+8; others -> 0 and `err`=1.
- OPq ifun: 0 add, 1 sub (valB-valA), 2 and, 3 xor; ifun>3 -> valE=0, `err`=1, no CC update.
- All arithmetic modulo 2^64; carry discarded.
- Flags: ZF = (t==0); SF = t[63]; OF add = (a[63]==b[63]) & (t[63]!=b[63]); OF sub = (a[63]!=b[63]) & (t[63]!=b[63]); OF and/xor = 0.
- CC written only on accepted valid OPq with `cc_inhibit`=0.
- cnd for icode 2/7 from current registered CC: ifun 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne ~ZF; 5 ge ~(SF^OF); 6 g ~(SF^OF)&~ZF; >6 -> cnd=0, `err`=1.
- cnd=0 for all other icodes.
- Output register holds its value while `out_valid & ~out_ready`.
- Output register clears `out_valid` when consumed with no new accept.

## Timing
- Reset values (rst_n=0 at edge): `out_valid`=0, `valE`=0, `cnd`=0, `dstE_out`=4'hF, `icode_out`=1 (nop), `err`=0, `cc`=3'b100.
- Reset has priority over everything; an in-flight result is dropped.
- Latency 1 cycle accept -> `out_valid`; throughput one per cycle when `out_ready`=1.
- Simultaneous consume and accept: register reloads, `out_valid` stays 1.
- Back-to-back OPq then jXX/cmov: the second instruction, accepted next cycle, sees the CC written by the first.
- CC is never written on a stalled (unaccepted) cycle.

## Structure
- Shared package `y86_pkg`: icode constants (IHALT..IPOPQ), ALU ifun codes (ALUADD/SUB/AND/XOR), condition codes (C_YES..C_G), RNONE, CC bit indices.
- Sub-module `alu64`: combinational W-bit add/sub/and/xor returning result, ZF, SF, OF.
- Stage owns operand muxing, CC register, condition logic and the output register.

## Test plan
- OPq add, valA=1, valB=64'h7FFF_FFFF_FFFF_FFFF -> valE=64'h8000_0000_0000_0000, cc={0,1,1}.
- OPq sub, valA=5, valB=5 -> valE=0, cc={1,0,0}; next-cycle jXX ifun 3 (je) -> cnd=1.
- cmovXX ifun 2 (cmovl) after cc={0,0,0}, dstE=3 -> cnd=0, dstE_out=4'hF, valE=valA.
- pushq valB=64'h100 with out_ready held 0 for 3 cycles -> valE=64'hF8 stable, in_ready=0, no second accept; release -> consumed.
- OPq and with `cc_inhibit`=1 -> cc unchanged; icode=4'hC -> err=1, valE=0.
- Assert rst_n=0 while out_valid=1 -> next cycle out_valid=0, cc=3'b100, dstE_out=4'hF.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, jump/cmov
// condition codes, the "no register" id and condition-code bit positions.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] ALUADD  = 4'h0;
    localparam logic [3:0] ALUSUB  = 4'h1;
    localparam logic [3:0] ALUAND  = 4'h2;
    localparam logic [3:0] ALUXOR  = 4'h3;

    localparam logic [3:0] C_YES   = 4'h0;
    localparam logic [3:0] C_LE    = 4'h1;
    localparam logic [3:0] C_L     = 4'h2;
    localparam logic [3:0] C_E     = 4'h3;
    localparam logic [3:0] C_NE    = 4'h4;
    localparam logic [3:0] C_GE    = 4'h5;
    localparam logic [3:0] C_G     = 4'h6;

    localparam logic [3:0] RNONE   = 4'hF;

    // Bit positions inside the {ZF,SF,OF} condition-code vector
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    // Value the condition codes take out of reset: ZF set, SF/OF clear
    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu64.sv
// Combinational ALU: add, subtract (b - a), and, xor with Z/S/O flags.
// Operand order follows Y86 OPq semantics where valB is the left operand.
module alu64 #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   fun_i,
    output logic [W-1:0] result_o,
    output logic         zf_o,
    output logic         sf_o,
    output logic         of_o
);

    logic [W-1:0] sumVal;
    logic [W-1:0] diffVal;

    assign sumVal  = b_i + a_i;
    assign diffVal = b_i - a_i;

    // Select the result and derive signed overflow for the chosen operation
    always_comb begin
        result_o = '0;
        of_o     = 1'b0;
        unique case (fun_i)
            2'd0: begin
                result_o = sumVal;
                of_o     = (a_i[W-1] == b_i[W-1]) && (sumVal[W-1] != b_i[W-1]);
            end
            2'd1: begin
                result_o = diffVal;
                of_o     = (a_i[W-1] != b_i[W-1]) && (diffVal[W-1] != b_i[W-1]);
            end
            2'd2: result_o = b_i & a_i;
            2'd3: result_o = b_i ^ a_i;
        endcase
    end

    assign zf_o = (result_o == '0);
    assign sf_o = result_o[W-1];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand selection, ALU, condition-code register,
// jump/cmov condition evaluation and a one-entry valid/ready output register.
module execute_stage
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] valA,
    input  logic [W-1:0] valB,
    input  logic [W-1:0] valC,
    input  logic [3:0]   dstE,
    input  logic         cc_inhibit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] valE,
    output logic         cnd,
    output logic [3:0]   dstE_out,
    output logic [3:0]   icode_out,
    output logic [2:0]   cc,
    output logic         err
);

    logic         outValid_q;
    logic [W-1:0] valE_q, valE_d;
    logic         cnd_q, cnd_d;
    logic [3:0]   dstE_q, dstE_d;
    logic [3:0]   icode_q;
    logic         err_q, err_d;
    logic [2:0]   cc_q, cc_d;

    logic         accept;
    logic         opValid;
    logic         condValid;
    logic         condTrue;
    logic         usesCond;
    logic         ccWrite;
    logic [W-1:0] aluResult;
    logic         aluZf, aluSf, aluOf;
    logic         zf, sf, of;

    assign in_ready = ~outValid_q | out_ready;
    assign accept   = in_valid & in_ready;

    alu64 #(.W(W)) u_alu (
        .a_i      (valA),
        .b_i      (valB),
        .fun_i    (ifun[1:0]),
        .result_o (aluResult),
        .zf_o     (aluZf),
        .sf_o     (aluSf),
        .of_o     (aluOf)
    );

    assign opValid  = (ifun <= ALUXOR);
    assign usesCond = (icode == IRRMOVQ) || (icode == IJXX);
    assign zf       = cc_q[CC_ZF];
    assign sf       = cc_q[CC_SF];
    assign of       = cc_q[CC_OF];

    // Evaluate the jump/cmov condition against the currently registered flags
    always_comb begin
        condValid = 1'b1;
        condTrue  = 1'b0;
        case (ifun)
            C_YES:   condTrue = 1'b1;
            C_LE:    condTrue = (sf ^ of) | zf;
            C_L:     condTrue = sf ^ of;
            C_E:     condTrue = zf;
            C_NE:    condTrue = ~zf;
            C_GE:    condTrue = ~(sf ^ of);
            C_G:     condTrue = ~(sf ^ of) & ~zf;
            default: condValid = 1'b0;
        endcase
    end

    // Pick the execute result per instruction and flag unknown encodings
    always_comb begin
        valE_d = '0;
        err_d  = 1'b0;
        case (icode)
            IHALT, INOP:      valE_d = '0;
            IRRMOVQ:          begin
                valE_d = valA;
                err_d  = ~condValid;
            end
            IIRMOVQ:          valE_d = valC;
            IRMMOVQ, IMRMOVQ: valE_d = valB + valC;
            IOPQ:             begin
                if (opValid) valE_d = aluResult;
                err_d = ~opValid;
            end
            IJXX:             begin
                valE_d = '0;
                err_d  = ~condValid;
            end
            ICALL, IPUSHQ:    valE_d = valB - W'(8);
            IRET, IPOPQ:      valE_d = valB + W'(8);
            default:          err_d  = 1'b1;
        endcase
    end

    // A false cmov must not write its destination, so its dstE becomes RNONE
    assign cnd_d   = usesCond & condValid & condTrue;
    assign dstE_d  = ((icode == IRRMOVQ) && !cnd_d) ? RNONE : dstE;

    // Flags only move on an accepted, well-formed OPq that is not inhibited
    assign ccWrite = accept && (icode == IOPQ) && opValid && !cc_inhibit;
    assign cc_d    = ccWrite ? {aluZf, aluSf, aluOf} : cc_q;

    // Condition-code register; reset drops any pending update
    always_ff @(posedge clk) begin
        if (!rst_n) cc_q <= CC_RESET;
        else        cc_q <= cc_d;
    end

    // Output register: load on accept, drop valid once consumed, else hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            valE_q     <= '0;
            cnd_q      <= 1'b0;
            dstE_q     <= RNONE;
            icode_q    <= INOP;
            err_q      <= 1'b0;
        end else if (accept) begin
            outValid_q <= 1'b1;
            valE_q     <= valE_d;
            cnd_q      <= cnd_d;
            dstE_q     <= dstE_d;
            icode_q    <= icode;
            err_q      <= err_d;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign out_valid = outValid_q;
    assign valE      = valE_q;
    assign cnd       = cnd_q;
    assign dstE_out  = dstE_q;
    assign icode_out = icode_q;
    assign cc        = cc_q;
    assign err       = err_q;

endmodule
